// File: rtl/fir_sample_loader.sv
// fir_sample_loader: upstream stage of the FIR datapath.
//   Accepts a valid/ready byte stream and writes the samples into the shared sample memory,
//   starting at a base address latched on arm. It then pulses the FIR engine's start with the
//   base addresses and sample count, waits for the engine's done edge (or a timeout), and
//   reports frame completion.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   arm, cfg_in_base, cfg_out_base   frame start and base addresses (accepted only in IDLE)
//   s_valid, s_data, s_last, s_ready sample stream
//   mem_addr, mem_data, mem_we       registered sample-memory write port
//   fir_start, fir_input_addr,
//   fir_output_addr, fir_sample_count, fir_done   FIR engine handshake
//   busy, frame_done, err_overflow, err_timeout   status
module fir_sample_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_SAMPLES = 512,
  parameter int unsigned TIMEOUT_CYC = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              fir_start,
  output logic [ADDR_W-1:0] fir_input_addr,
  output logic [ADDR_W-1:0] fir_output_addr,
  output logic [ADDR_W-1:0] fir_sample_count,
  input  logic              fir_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StFill, StKick, StWaitFir, StFinish} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   in_base_q, in_base_d;
  logic [ADDR_W-1:0]   out_base_q, out_base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                fir_done_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_to_q, err_to_d;
  logic                fir_rise;

  // A done level that is already high when WAIT_FIR begins must not look like an edge, so
  // the delayed copy is sampled in every state, not only while waiting.
  assign fir_rise = fir_done & ~fir_done_q;

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    timer_d    = timer_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    err_ovf_d  = err_ovf_q;
    err_to_d   = err_to_q;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          in_base_d  = cfg_in_base;
          out_base_d = cfg_out_base;
          count_d    = '0;
          err_ovf_d  = 1'b0;
          err_to_d   = 1'b0;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (s_valid) begin
          mem_we_d   = 1'b1;
          mem_addr_d = in_base_q + count_q;
          mem_data_d = s_data;
          count_d    = count_q + ADDR_W'(1);
          if (s_last) begin
            state_d = StKick;
          end else if (count_q == LastIdx) begin
            // Frame full without a last marker: truncate and flag it.
            err_ovf_d = 1'b1;
            state_d   = StKick;
          end
        end
      end
      StKick: begin
        timer_d = '0;
        state_d = StWaitFir;
      end
      StWaitFir: begin
        if (fir_rise) begin
          state_d = StFinish;
        end else if (timer_q == TimerMax) begin
          err_to_d = 1'b1;
          state_d  = StFinish;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_base_q  <= '0;
      out_base_q <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      fir_done_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_ovf_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      fir_done_q <= fir_done;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_ovf_q  <= err_ovf_d;
      err_to_q   <= err_to_d;
    end
  end

  // Status strobes decode directly from the state register.
  assign s_ready          = (state_q == StFill);
  assign fir_start        = (state_q == StKick);
  assign frame_done       = (state_q == StFinish);
  assign busy             = (state_q != StIdle);
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_data         = mem_data_q;
  assign fir_input_addr   = in_base_q;
  assign fir_output_addr  = out_base_q;
  // Stops counting at KICK and is only cleared by the next arm, so it stays stable for the FIR.
  assign fir_sample_count = count_q;
  assign err_overflow     = err_ovf_q;
  assign err_timeout      = err_to_q;

endmodule

// File: tb/tb_fir_sample_loader.sv
// Self-checking bench for fir_sample_loader. Accepted beats push the expected memory write onto a
// scoreboard queue; a negedge monitor pops and compares every write and checks write latency.
module tb_fir_sample_loader;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXS = 512;
  localparam int unsigned TO   = 16;
  localparam int unsigned OW   = 4 * AW + DW + 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] cfg_in_base = '0;
  logic [AW-1:0] cfg_out_base = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          fir_start;
  logic [AW-1:0] fir_input_addr;
  logic [AW-1:0] fir_output_addr;
  logic [AW-1:0] fir_sample_count;
  logic          fir_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err_overflow;
  logic          err_timeout;

  always #5 clk = ~clk;

  fir_sample_loader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_SAMPLES (MAXS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arm              (arm),
    .cfg_in_base      (cfg_in_base),
    .cfg_out_base     (cfg_out_base),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .mem_we           (mem_we),
    .fir_start        (fir_start),
    .fir_input_addr   (fir_input_addr),
    .fir_output_addr  (fir_output_addr),
    .fir_sample_count (fir_sample_count),
    .fir_done         (fir_done),
    .busy             (busy),
    .frame_done       (frame_done),
    .err_overflow     (err_overflow),
    .err_timeout      (err_timeout)
  );

  logic [OW-1:0] all_outs;
  assign all_outs = {s_ready, mem_addr, mem_data, mem_we, fir_start, fir_input_addr,
                     fir_output_addr, fir_sample_count, busy, frame_done, err_overflow,
                     err_timeout};

  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];
  int start_cnt = 0, done_cnt = 0, wr_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
  bit mon_en = 1'b0;
  bit acc_prev = 1'b0;

  // Monitor: a beat accepted at a posedge must be written during the following cycle.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    cyc++;
    if (fir_start === 1'b1) begin start_cnt++; start_cyc = cyc; end
    if (frame_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (mon_en) begin
      total++;
      if (mem_we !== acc_prev) begin
        bad++;
        $display("FAIL mem_we_timing: got %b want %b (cycle %0d)", mem_we, acc_prev, cyc);
      end
      if (mem_we === 1'b1) begin
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h want no write", mem_addr,
                   mem_data);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_data} !== e) begin
            bad++;
            $display("FAIL write: got addr %0d data %0h want addr %0d data %0h", mem_addr,
                     mem_data, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
    end
    acc_prev = rst_n && s_valid && s_ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    cfg_in_base  = ib;
    cfg_out_base = ob;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Offer n beats; stops at the first beat refused while valid.
  task automatic send_frame(input int n, input logic [AW-1:0] base, input int seed,
                            input bit gappy, input bit use_last,
                            output int accepted, output int rejected_at);
    int i;
    int c;
    logic [AW-1:0] a;
    i = 0;
    c = 0;
    accepted = 0;
    rejected_at = -1;
    while (i < n && c < 4 * n + 20) begin
      s_valid = gappy ? (c % 2 == 0) : 1'b1;
      s_data  = s_valid ? DW'(i + seed) : 8'hEE;
      s_last  = use_last && (i == n - 1);
      @(negedge clk);
      if (s_valid && s_ready) begin
        a = base + AW'(i);
        exp_q.push_back({a, DW'(i + seed)});
        i++;
        accepted++;
      end else if (s_valid && !s_ready) begin
        rejected_at = i;
        s_valid = 1'b0;
        s_last = 1'b0;
        tick();
        break;
      end
      tick();
      c++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for the start pulse, optionally emulate the FIR (clear done, raise it after delay),
  // then wait for frame_done and check both pulses occurred exactly once.
  task automatic run_fir(input int st0, input int dn0, input bit respond, input int delay);
    int n;
    n = 0;
    while (start_cnt == st0 && n < 50) begin tick(); n++; end
    total++;
    if (start_cnt == st0) begin
      bad++;
      $display("FAIL fir_start_seen: got none want one pulse");
    end
    if (respond) begin
      fir_done = 1'b0;
      repeat (delay) tick();
      fir_done = 1'b1;
    end
    n = 0;
    while (done_cnt == dn0 && n < int'(TO) + 50) begin tick(); n++; end
    repeat (3) tick();
    total++;
    if (done_cnt != dn0 + 1) begin
      bad++;
      $display("FAIL frame_done_pulses: got %0d want 1", done_cnt - dn0);
    end
    total++;
    if (start_cnt != st0 + 1) begin
      bad++;
      $display("FAIL fir_start_pulses: got %0d want 1", start_cnt - st0);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int acc, rej, st0, dn0, w0;
    st0 = start_cnt; dn0 = done_cnt; w0 = wr_cnt;
    do_arm(10'd0, 10'd512);
    send_frame(8, 10'd0, 1, 1'b0, 1'b1, acc, rej);
    run_fir(st0, dn0, 1'b1, 3);
    chk("basic_accepted", acc, 8);
    chk("basic_writes", wr_cnt - w0, 8);
    chk("basic_queue_left", exp_q.size(), 0);
    chk("basic_sample_count", int'(fir_sample_count), 8);
    chk("basic_in_addr", int'(fir_input_addr), 0);
    chk("basic_out_addr", int'(fir_output_addr), 512);
    // done raised 'delay' cycles after start is seen; one cycle to register it, one to FINISH
    chk("basic_done_latency", done_cyc - start_cyc, 5);
    chk("basic_err_overflow", int'(err_overflow), 0);
    chk("basic_err_timeout", int'(err_timeout), 0);
    chk("basic_busy_after", int'(busy), 0);
  endtask

  task automatic test_gappy();
    int acc, rej, st0, dn0, w0;
    st0 = start_cnt; dn0 = done_cnt; w0 = wr_cnt;
    do_arm(10'd200, 10'd700);
    send_frame(5, 10'd200, 'h40, 1'b1, 1'b1, acc, rej);
    run_fir(st0, dn0, 1'b1, 2);
    chk("gappy_accepted", acc, 5);
    chk("gappy_writes", wr_cnt - w0, 5);
    chk("gappy_queue_left", exp_q.size(), 0);
    chk("gappy_sample_count", int'(fir_sample_count), 5);
  endtask

  task automatic test_wrap();
    int acc, rej, st0, dn0, w0;
    st0 = start_cnt; dn0 = done_cnt; w0 = wr_cnt;
    do_arm(10'd1020, 10'd4);
    send_frame(6, 10'd1020, 'h90, 1'b0, 1'b1, acc, rej);
    run_fir(st0, dn0, 1'b1, 1);
    chk("wrap_writes", wr_cnt - w0, 6);
    chk("wrap_queue_left", exp_q.size(), 0);
    chk("wrap_in_addr", int'(fir_input_addr), 1020);
    chk("wrap_out_addr", int'(fir_output_addr), 4);
  endtask

  task automatic test_overflow();
    int acc, rej, st0, dn0, w0;
    st0 = start_cnt; dn0 = done_cnt; w0 = wr_cnt;
    do_arm(10'd300, 10'd5);
    send_frame(600, 10'd300, 7, 1'b0, 1'b0, acc, rej);
    run_fir(st0, dn0, 1'b1, 2);
    chk("ovf_accepted", acc, int'(MAXS));
    chk("ovf_first_refused_beat", rej, int'(MAXS));
    chk("ovf_writes", wr_cnt - w0, int'(MAXS));
    chk("ovf_queue_left", exp_q.size(), 0);
    chk("ovf_err_overflow", int'(err_overflow), 1);
    chk("ovf_err_timeout", int'(err_timeout), 0);
    chk("ovf_sample_count", int'(fir_sample_count), int'(MAXS));
  endtask

  task automatic test_timeout();
    int acc, rej, st0, dn0;
    fir_done = 1'b1;
    repeat (3) tick();
    st0 = start_cnt; dn0 = done_cnt;
    do_arm(10'd40, 10'd80);
    send_frame(4, 10'd40, 'h11, 1'b0, 1'b1, acc, rej);
    run_fir(st0, dn0, 1'b0, 0);
    // TIMEOUT_CYC cycles in WAIT_FIR after the KICK cycle, then FINISH
    chk("to_done_latency", done_cyc - start_cyc, int'(TO) + 1);
    chk("to_err_timeout", int'(err_timeout), 1);
    chk("to_err_overflow_cleared", int'(err_overflow), 0);
    chk("to_sample_count", int'(fir_sample_count), 4);
  endtask

  task automatic test_reset_mid();
    int acc, rej, st0, dn0, w0;
    fir_done = 1'b0;
    st0 = start_cnt;
    do_arm(10'd50, 10'd60);
    send_frame(3, 10'd50, 'h20, 1'b0, 1'b0, acc, rej);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0", all_outs);
    end
    chk("midreset_queue_left", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    repeat (3) tick();
    chk("midreset_no_start", start_cnt - st0, 0);
    st0 = start_cnt; dn0 = done_cnt; w0 = wr_cnt;
    do_arm(10'd100, 10'd0);
    send_frame(2, 10'd100, 'h33, 1'b0, 1'b1, acc, rej);
    run_fir(st0, dn0, 1'b1, 2);
    chk("rearm_writes", wr_cnt - w0, 2);
    chk("rearm_queue_left", exp_q.size(), 0);
    chk("rearm_sample_count", int'(fir_sample_count), 2);
    chk("rearm_in_addr", int'(fir_input_addr), 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gappy();
    test_wrap();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
